cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Coprocessor-0 block in the MIPS 5-stage pipeline, sitting beside the M stage.
- Holds SR (12), Cause (13), EPC (14) and PRId (15), and arbitrates hardware interrupts against synchronous exceptions.
- Drives the req flush that the downstream pipeline registers consume: the W register clears its payload and loads PC 0x0000_4180.
- Provides EPC to the F stage for eret, and serves mfc0/mtc0 accesses.

Parameters:
- PRID, 32'h0000_2023, read-only value of register 15.
- HANDLER_PC, 32'h0000_4180, exception entry address driven on handler_pc.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- we  in  1  mtc0 write enable (M stage)
- addr  in  5  CP0 register number, for read and write
- wdata  in  32  mtc0 data
- rdata  out  32  mfc0 read data (combinational)
- pc_in  in  32  PC of the instruction currently in M
- bd_in  in  1  that instruction is in a branch delay slot
- exc_code_in  in  5  exception code of the M instruction; 0 = none
- eret_in  in  1  eret is in M
- hw_int  in  6  external interrupt lines, level-sensitive
- req  out  1  flush/redirect request (combinational)
- epc_out  out  32  return address for eret
- handler_pc  out  32  constant HANDLER_PC

Behaviour:
- SR layout: IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
- Cause layout: BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
- Reset (posedge with rst = 1): SR, Cause and EPC all become 0. req = 0 while rst is high, regardless of inputs.
- int_req = IE & ~EXL & |(IM & hw_int).
- exc_req = (exc_code_in != 0) & ~EXL.
- req = ~rst & (int_req | exc_req). The interrupt has priority over a simultaneous exception.
- req is same-cycle combinational. All register updates happen at the following posedge. Latency from a hw_int edge to req is 0 cycles when enabled.
- Effects of req at the posedge:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= (bd_in ? pc_in - 4 : pc_in) & ~32'h3 (modulo-2^32 wrap).
- Cause.IP <= hw_int every cycle, including cycles with req, so software sees live pending lines. Only reset clears it.
- mtc0 (we = 1, req = 0):
  - addr 12 writes IM/EXL/IE only.
  - addr 14 writes wdata & ~3.
  - addr 13, 15 and all others are ignored.
- mtc0 in the same cycle as req: the write is dropped and the exception update wins.
- eret_in = 1 with req = 0: EXL <= 0 at the posedge.
- eret with EXL already 0 is legal: EXL stays 0 and there is no other effect.
- eret in the same cycle as req cannot occur while EXL = 1. If it occurs with EXL = 0, req wins.
- epc_out = (we & addr == 14) ? (wdata & ~3) : EPC. This forwards an mtc0 that immediately precedes eret.
- rdata by addr:
  - 12 → SR
  - 13 → Cause
  - 14 → EPC
  - 15 → PRID
  - any other → 0
  - rdata reflects register state before the current cycle's write.
- Nested requests: while EXL = 1, both int_req and exc_req are 0. hw_int is still recorded in IP.
- rst asserted mid-handler: EXL is cleared and the pending interrupt state is discarded.

Decomposition:
- Shared package mips_cp0_pkg holds:
  - register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15
  - ExcCodes: Int = 0, AdEL = 4, AdES = 5, Syscall = 8, RI = 10, Ov = 12
  - bit-field positions and write masks for SR and Cause
- No sub-module: single flat block, roughly 150 RTL lines.

Test Plan:
- Reset, then read regs 12/13/14/15 → rdata = 0 / 0 / 0 / PRID, and req = 0.
- mtc0 SR = 32'h0000_FC01, then hw_int = 6'b000100 with pc_in = 32'h0000_3010 → req = 1 the same cycle. Next cycle: Cause = 32'h0000_1000, EPC = 32'h0000_3010, EXL = 1, req = 0 while hw_int stays high.
- exc_code_in = 12 (Ov) with bd_in = 1, pc_in = 32'h0000_3024, IE = 0 → req = 1. Next cycle: Cause = 32'h8000_0030, EPC = 32'h0000_3020.
- hw_int enabled and exc_code_in = 10 in the same cycle → ExcCode = 0, EPC = pc_in. Simultaneous mtc0 SR = 0 is dropped.
- In handler: mtc0 EPC = 32'h0000_3103 followed by eret the next cycle → epc_out = 32'h0000_3100 in both cycles, then EXL = 0 and a pending enabled interrupt raises req.
- rst asserted while EXL = 1 and hw_int active → next cycle SR = Cause = EPC = 0, and req = 0 throughout the reset cycle.

Source files
------------

// File: rtl/mips_cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and write masks for SR and Cause.
// Imported by cp0_exception_unit. Contains no logic.
package mips_cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // SR fields
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LSB  = 10;
  localparam int SR_IM_MSB  = 15;

  // Cause fields
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  // Software-writable bits: SR keeps IM/EXL/IE only, EPC is word aligned
  localparam logic [31:0] SR_WMASK  = 32'h0000_FC03;
  localparam logic [31:0] EPC_WMASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cp0_exception_unit.sv
// Coprocessor 0 beside the M stage: SR/Cause/EPC/PRId, interrupt vs exception
// arbitration, pipeline flush request, EPC for eret, mfc0/mtc0 access.
// Ports: clk/rst (sync, active-high); we/addr/wdata/rdata = mtc0/mfc0;
//   pc_in/bd_in/exc_code_in/eret_in = M-stage instruction; hw_int = IRQ lines;
//   req = same-cycle flush; epc_out = eret target; handler_pc = vector.
module cp0_exception_unit
  import mips_cp0_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h0000_2023,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc_in,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        eret_in,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  // SR is held as a full word with non-writable bits always zero
  logic [31:0] sr_q, sr_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        exl;
  logic        ie;
  logic [5:0]  im;
  logic        int_req;
  logic        exc_req;
  logic [31:0] cause_word;

  assign exl = sr_q[SR_EXL_BIT];
  assign ie  = sr_q[SR_IE_BIT];
  assign im  = sr_q[SR_IM_MSB:SR_IM_LSB];

  // EXL masks both sources, so nested requests never fire inside a handler
  assign int_req = ie & ~exl & (|(im & hw_int));
  assign exc_req = (exc_code_in != 5'd0) & ~exl;
  assign req     = ~rst & (int_req | exc_req);

  always_comb begin
    cause_word = 32'd0;
    cause_word[CAUSE_BD_BIT]                = cause_bd_q;
    cause_word[CAUSE_IP_MSB:CAUSE_IP_LSB]   = cause_ip_q;
    cause_word[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_exc_q;
  end

  // Reads see register state before this cycle's write
  always_comb begin
    unique case (addr)
      CP0_SR:    rdata = sr_q;
      CP0_CAUSE: rdata = cause_word;
      CP0_EPC:   rdata = epc_q;
      CP0_PRID:  rdata = PRID;
      default:   rdata = 32'd0;
    endcase
  end

  // Forward an mtc0 EPC so an eret in the very next cycle sees the new value
  assign epc_out    = (we && addr == CP0_EPC) ? (wdata & EPC_WMASK) : epc_q;
  assign handler_pc = HANDLER_PC;

  always_comb begin
    sr_d        = sr_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    // IP tracks the raw lines every cycle, even while taking an exception
    cause_ip_d  = hw_int;

    if (req) begin
      // Exception entry overrides any concurrent mtc0 or eret
      sr_d[SR_EXL_BIT] = 1'b1;
      cause_bd_d       = bd_in;
      cause_exc_d      = int_req ? EXC_INT : exc_code_in;
      epc_d            = (bd_in ? (pc_in - 32'd4) : pc_in) & EPC_WMASK;
    end else begin
      if (we && addr == CP0_SR)  sr_d  = wdata & SR_WMASK;
      if (we && addr == CP0_EPC) epc_d = wdata & EPC_WMASK;
      if (eret_in)               sr_d[SR_EXL_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= 32'd0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_q        <= sr_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
module tb_cp0_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc_in;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret_in;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  always #5 clk = ~clk;

  cp0_exception_unit dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .pc_in(pc_in), .bd_in(bd_in), .exc_code_in(exc_code_in), .eret_in(eret_in),
    .hw_int(hw_int), .req(req), .epc_out(epc_out), .handler_pc(handler_pc)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural register words
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_int_req();
    return m_sr[0] && !m_sr[1] && ((m_sr[15:10] & hw_int) != 6'd0);
  endfunction

  function automatic logic m_req();
    return !rst && (m_int_req() || (!m_sr[1] && exc_code_in != 5'd0));
  endfunction

  function automatic logic [31:0] m_rdata();
    case (addr)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_2023;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_out();
    return (we && addr == 5'd14) ? {wdata[31:2], 2'b00} : m_epc;
  endfunction

  task automatic model_clock();
    logic        r;
    logic        ir;
    logic [31:0] ret;
    r  = m_req();
    ir = m_int_req();
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (r) begin
      m_sr    = m_sr | 32'h2;
      m_cause = ({31'd0, bd_in} << 31) | ({26'd0, hw_int} << 10)
              | ({27'd0, (ir ? 5'd0 : exc_code_in)} << 2);
      ret     = bd_in ? pc_in - 32'd4 : pc_in;
      m_epc   = {ret[31:2], 2'b00};
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
      if (we && addr == 5'd12) m_sr  = wdata & 32'h0000_FC03;
      if (we && addr == 5'd14) m_epc = {wdata[31:2], 2'b00};
      if (eret_in)             m_sr  = m_sr & ~32'h2;
    end
  endtask

  // Sample outputs mid-cycle, then advance the clock and the model together
  task automatic cycle(input bit use_model);
    @(negedge clk);
    if (use_model) begin
      chk("rnd_req",     {31'd0, req}, {31'd0, m_req()});
      chk("rnd_rdata",   rdata,   m_rdata());
      chk("rnd_epc_out", epc_out, m_epc_out());
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        eret;
    logic [5:0]  hw;
    logic        exp_req;
    logic [31:0] exp_rdata;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic r, logic w, logic [4:0] a, logic [31:0] wd,
                              logic [31:0] pc, logic bd, logic [4:0] ex, logic er,
                              logic [5:0] hw, logic q, logic [31:0] rd, logic [31:0] ep);
    vec_t v;
    v.rst = r; v.we = w; v.addr = a; v.wdata = wd; v.pc = pc; v.bd = bd;
    v.exc = ex; v.eret = er; v.hw = hw; v.exp_req = q; v.exp_rdata = rd; v.exp_epc = ep;
    return v;
  endfunction

  initial begin
    // Sequential vectors starting from the reset state; each row is one cycle
    //             rst we addr   wdata          pc            bd exc    er hw        req rdata          epc_out
    tbl[0]  = mk(0, 0, 5'd12, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0,          32'h0);
    tbl[1]  = mk(0, 0, 5'd13, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0,          32'h0);
    tbl[2]  = mk(0, 0, 5'd14, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0,          32'h0);
    tbl[3]  = mk(0, 0, 5'd15, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0000_2023,  32'h0);
    tbl[4]  = mk(0, 1, 5'd12, 32'h0000_FC01,  32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0,          32'h0);
    tbl[5]  = mk(0, 0, 5'd12, 32'h0,          32'h0000_3010,0, 5'd0,  0, 6'b000100, 1, 32'h0000_FC01,  32'h0);
    tbl[6]  = mk(0, 0, 5'd13, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000100, 0, 32'h0000_1000,  32'h0000_3010);
    tbl[7]  = mk(0, 0, 5'd14, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000100, 0, 32'h0000_3010,  32'h0000_3010);
    tbl[8]  = mk(0, 0, 5'd12, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000100, 0, 32'h0000_FC03,  32'h0000_3010);
    tbl[9]  = mk(0, 1, 5'd12, 32'h0000_FC00,  32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0000_FC03,  32'h0000_3010);
    tbl[10] = mk(0, 0, 5'd13, 32'h0,          32'h0000_3024,1, 5'd12, 0, 6'b000000, 1, 32'h0,          32'h0000_3010);
    tbl[11] = mk(0, 0, 5'd13, 32'h0,          32'h0,        0, 5'd12, 0, 6'b000000, 0, 32'h8000_0030,  32'h0000_3020);
    tbl[12] = mk(0, 0, 5'd14, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0000_3020,  32'h0000_3020);
    tbl[13] = mk(0, 0, 5'd12, 32'h0,          32'h0,        0, 5'd0,  1, 6'b000000, 0, 32'h0000_FC02,  32'h0000_3020);
    tbl[14] = mk(0, 1, 5'd12, 32'h0000_FC01,  32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0000_FC00,  32'h0000_3020);
    tbl[15] = mk(0, 1, 5'd12, 32'h0,          32'h0000_3040,0, 5'd10, 0, 6'b000001, 1, 32'h0000_FC01,  32'h0000_3020);
    tbl[16] = mk(0, 0, 5'd13, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000001, 0, 32'h0000_0400,  32'h0000_3040);
    tbl[17] = mk(0, 0, 5'd12, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000001, 0, 32'h0000_FC03,  32'h0000_3040);
    tbl[18] = mk(0, 1, 5'd14, 32'h0000_3103,  32'h0,        0, 5'd0,  0, 6'b000001, 0, 32'h0000_3040,  32'h0000_3100);
    tbl[19] = mk(0, 0, 5'd14, 32'h0,          32'h0,        0, 5'd0,  1, 6'b000001, 0, 32'h0000_3100,  32'h0000_3100);
    tbl[20] = mk(0, 0, 5'd12, 32'h0,          32'h0000_3100,0, 5'd0,  0, 6'b000001, 1, 32'h0000_FC01,  32'h0000_3100);
    tbl[21] = mk(1, 0, 5'd12, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000001, 0, 32'h0000_FC03,  32'h0000_3100);
    tbl[22] = mk(0, 0, 5'd13, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000001, 0, 32'h0,          32'h0);
    tbl[23] = mk(0, 0, 5'd13, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0000_0400,  32'h0);
    tbl[24] = mk(1, 0, 5'd12, 32'h0,          32'h0,        0, 5'd5,  0, 6'b111111, 0, 32'h0,          32'h0);
    tbl[25] = mk(0, 0, 5'd14, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h0,          32'h0);
    tbl[26] = mk(0, 0, 5'd14, 32'h0,          32'h0000_0002,1, 5'd4,  0, 6'b000000, 1, 32'h0,          32'h0);
    tbl[27] = mk(0, 0, 5'd14, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'hFFFF_FFFC,  32'hFFFF_FFFC);
    tbl[28] = mk(0, 0, 5'd13, 32'h0,          32'h0,        0, 5'd0,  0, 6'b000000, 0, 32'h8000_0010,  32'hFFFF_FFFC);

    rst = 1; we = 0; addr = 0; wdata = 0; pc_in = 0; bd_in = 0;
    exc_code_in = 0; eret_in = 0; hw_int = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;

    // Initial reset; hold an exception request to show req stays low
    @(posedge clk); #1;
    exc_code_in = 5'd8;
    @(negedge clk);
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("handler_pc", handler_pc, 32'h0000_4180);
    @(posedge clk); #1;
    rst = 0; exc_code_in = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;

    for (int i = 0; i < 29; i++) begin
      rst = tbl[i].rst; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata;
      pc_in = tbl[i].pc; bd_in = tbl[i].bd; exc_code_in = tbl[i].exc;
      eret_in = tbl[i].eret; hw_int = tbl[i].hw;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i),   {31'd0, req}, {31'd0, tbl[i].exp_req});
      chk($sformatf("vec%0d_rdata", i), rdata,   tbl[i].exp_rdata);
      chk($sformatf("vec%0d_epc", i),   epc_out, tbl[i].exp_epc);
      @(posedge clk);
      model_clock();
      #1;
    end

    // Model must agree with the hand-derived table before random checking
    chk("model_sync_sr",    m_sr,    32'h0000_0002);
    chk("model_sync_epc",   m_epc,   32'hFFFF_FFFC);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      we          = ($urandom_range(0, 3) == 0);
      addr        = 5'($urandom_range(10, 17));
      wdata       = $urandom;
      pc_in       = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bd_in       = 1'($urandom_range(0, 1));
      exc_code_in = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      eret_in     = ($urandom_range(0, 5) == 0);
      hw_int      = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      cycle(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
